// File: rtl/alu_8_arbiter.sv
// Two-requester arbiter for one shared 8-bit combinational ALU.
// A granted operation is held on the ALU for OP_LATENCY cycles, then its result goes back to the requester that owns it.
module alu_8_arbiter #(
  parameter int OP_LATENCY = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [4:0] req0_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [4:0] req1_op,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp0_out,
  output logic [7:0] rsp1_out,
  output logic [7:0] rsp0_flags,
  output logic [7:0] rsp1_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_flags,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state_reg;
  logic [3:0] cnt_reg;
  logic       owner_reg;
  logic       last_grant_reg;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [4:0] op_reg;
  logic [7:0] result_reg;
  logic [7:0] flags_reg;

  logic       grant_port;
  logic       in_idle;
  logic       active;
  logic       rsp_fire;
  logic       accept;

  // A tie goes to port 0 under fixed priority, otherwise to the port not served last.
  always_comb begin
    grant_port = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_port = FIXED_PRIO ? 1'b0 : ~last_grant_reg;
    end else begin
      grant_port = req1_valid;
    end
  end

  // Every output is forced low while rst is high, even before the reset edge.
  assign in_idle    = (state_reg == IDLE) && !rst;
  assign active     = (state_reg != IDLE) && !rst;
  assign rsp_fire   = (state_reg == DONE) && !rst;
  assign req0_ready = in_idle && req0_valid && !grant_port;
  assign req1_ready = in_idle && req1_valid && grant_port;
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      a_reg          <= 8'd0;
      b_reg          <= 8'd0;
      op_reg         <= 5'd0;
      result_reg     <= 8'd0;
      flags_reg      <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg          <= grant_port ? req1_a : req0_a;
            b_reg          <= grant_port ? req1_b : req0_b;
            op_reg         <= grant_port ? req1_op : req0_op;
            owner_reg      <= grant_port;
            last_grant_reg <= grant_port;
            cnt_reg        <= 4'(OP_LATENCY - 1);
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt_reg == 4'd0) begin
            result_reg <= alu_out;
            flags_reg  <= alu_flags;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = active ? a_reg : 8'd0;
  assign alu_b      = active ? b_reg : 8'd0;
  assign alu_opcode = active ? op_reg : 5'd0;
  assign busy       = active;

  logic [1:0] rsp_sel;
  logic [7:0] rsp_out_vec   [2];
  logic [7:0] rsp_flags_vec [2];

  assign rsp_sel[0] = rsp_fire && !owner_reg;
  assign rsp_sel[1] = rsp_fire && owner_reg;

  // Response data is zero outside the single pulse cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_out_vec[gi]   = rsp_sel[gi] ? result_reg : 8'd0;
      assign rsp_flags_vec[gi] = rsp_sel[gi] ? flags_reg : 8'd0;
    end
  endgenerate

  assign rsp0_valid = rsp_sel[0];
  assign rsp1_valid = rsp_sel[1];
  assign rsp0_out   = rsp_out_vec[0];
  assign rsp1_out   = rsp_out_vec[1];
  assign rsp0_flags = rsp_flags_vec[0];
  assign rsp1_flags = rsp_flags_vec[1];

endmodule

// File: tb/tb_alu_8_arbiter.sv
// Bench for alu_8_arbiter. It runs three instances: round-robin at latency 1, fixed priority at latency 1, and round-robin at latency 4.
// A window-based model checks every output on every cycle, and hand-computed literals pin the model.
module tb_alu_8_arbiter;

  localparam int N = 3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] op;
  } op_t;

  logic       clk;
  logic       rst        [N];
  logic       v0         [N];
  logic       v1         [N];
  logic       r0         [N];
  logic       r1         [N];
  logic [7:0] a0         [N];
  logic [7:0] b0         [N];
  logic [4:0] op0        [N];
  logic [7:0] a1         [N];
  logic [7:0] b1         [N];
  logic [4:0] op1        [N];
  logic       rv0        [N];
  logic       rv1        [N];
  logic [7:0] ro0        [N];
  logic [7:0] ro1        [N];
  logic [7:0] rf0        [N];
  logic [7:0] rf1        [N];
  logic [7:0] alu_a      [N];
  logic [7:0] alu_b      [N];
  logic [4:0] alu_op     [N];
  logic [7:0] alu_out    [N];
  logic [7:0] alu_flags  [N];
  logic       busy       [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Opcode set of the stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 DEC, anything else gives 0.
  function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [4:0] op);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return a + 8'd1;
      5'd6: return a - 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] flg_fn(logic [7:0] r);
    return {r[7], 6'd0, (r == 8'd0)};
  endfunction

  function automatic int lat_of(int i);
    return (i == 2) ? 4 : 1;
  endfunction

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      alu_8_arbiter #(
        .OP_LATENCY((gi == 2) ? 4 : 1),
        .FIXED_PRIO(gi == 1)
      ) u_dut (
        .clk(clk), .rst(rst[gi]),
        .req0_valid(v0[gi]), .req1_valid(v1[gi]),
        .req0_ready(r0[gi]), .req1_ready(r1[gi]),
        .req0_a(a0[gi]), .req0_b(b0[gi]), .req0_op(op0[gi]),
        .req1_a(a1[gi]), .req1_b(b1[gi]), .req1_op(op1[gi]),
        .rsp0_valid(rv0[gi]), .rsp1_valid(rv1[gi]),
        .rsp0_out(ro0[gi]), .rsp1_out(ro1[gi]),
        .rsp0_flags(rf0[gi]), .rsp1_flags(rf1[gi]),
        .alu_a(alu_a[gi]), .alu_b(alu_b[gi]), .alu_opcode(alu_op[gi]),
        .alu_out(alu_out[gi]), .alu_flags(alu_flags[gi]),
        .busy(busy[gi])
      );
      assign alu_out[gi]   = alu_fn(alu_a[gi], alu_b[gi], alu_op[gi]);
      assign alu_flags[gi] = flg_fn(alu_fn(alu_a[gi], alu_b[gi], alu_op[gi]));
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each requester keeps a queue of pending operations and asserts valid while the queue is not empty.
  op_t qmem [N][2][16];
  int  qh   [N][2];
  int  qt   [N][2];
  bit  pend [N][2];

  // The model tracks one operation in flight per instance by its accept edge.
  bit  m_inf  [N];
  int  m_acc  [N];
  bit  m_own  [N];
  bit  m_last [N];
  op_t m_op   [N];

  // Transaction logs that the literal checks read.
  int         g_cnt  [N];
  bit         g_port [N][16];
  int         g_cyc  [N][16];
  int         r_cnt  [N];
  bit         r_port [N][16];
  logic [7:0] r_out  [N][16];
  logic [7:0] r_flg  [N][16];
  int         r_cyc  [N][16];
  int         fp_r1_while_p0;
  bit         seen_1f;

  task automatic chk(string name, int i, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d got %h want %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic push(int i, int p, logic [7:0] a, logic [7:0] b, logic [4:0] op);
    op_t e;
    e.a = a;
    e.b = b;
    e.op = op;
    qmem[i][p][qt[i][p]] = e;
    qt[i][p]++;
  endtask

  task automatic drive(int i);
    op_t h0;
    op_t h1;
    h0 = '0;
    h1 = '0;
    v0[i] = (qh[i][0] < qt[i][0]);
    v1[i] = (qh[i][1] < qt[i][1]);
    if (v0[i]) h0 = qmem[i][0][qh[i][0]];
    if (v1[i]) h1 = qmem[i][1][qh[i][1]];
    a0[i] = h0.a; b0[i] = h0.b; op0[i] = h0.op;
    a1[i] = h1.a; b1[i] = h1.b; op1[i] = h1.op;
  endtask

  task automatic compare(int i);
    bit         e_busy;
    bit         e_done;
    bit         e_idle;
    bit         gp1;
    bit         e_r0;
    bit         e_r1;
    op_t        e_alu;
    logic [7:0] res;
    logic [7:0] flg;
    e_busy = !rst[i] && m_inf[i];
    e_done = e_busy && (cyc == m_acc[i] + lat_of(i));
    e_idle = !rst[i] && !m_inf[i];
    if (v0[i] && v1[i]) gp1 = (i == 1) ? 1'b0 : !m_last[i];
    else gp1 = v1[i];
    e_r0 = e_idle && v0[i] && !gp1;
    e_r1 = e_idle && v1[i] && gp1;
    e_alu = e_busy ? m_op[i] : '0;
    res = alu_fn(m_op[i].a, m_op[i].b, m_op[i].op);
    flg = flg_fn(res);

    chk("req0_ready", i, 8'(r0[i]), 8'(e_r0));
    chk("req1_ready", i, 8'(r1[i]), 8'(e_r1));
    chk("busy", i, 8'(busy[i]), 8'(e_busy));
    chk("alu_a", i, alu_a[i], e_alu.a);
    chk("alu_b", i, alu_b[i], e_alu.b);
    chk("alu_opcode", i, 8'(alu_op[i]), 8'(e_alu.op));
    chk("rsp0_valid", i, 8'(rv0[i]), 8'(e_done && !m_own[i]));
    chk("rsp1_valid", i, 8'(rv1[i]), 8'(e_done && m_own[i]));
    chk("rsp0_out", i, ro0[i], (e_done && !m_own[i]) ? res : 8'd0);
    chk("rsp1_out", i, ro1[i], (e_done && m_own[i]) ? res : 8'd0);
    chk("rsp0_flags", i, rf0[i], (e_done && !m_own[i]) ? flg : 8'd0);
    chk("rsp1_flags", i, rf1[i], (e_done && m_own[i]) ? flg : 8'd0);

    if ((r0[i] && v0[i]) || (r1[i] && v1[i])) begin
      pend[i][0] = r0[i] && v0[i];
      pend[i][1] = r1[i] && v1[i];
      if (g_cnt[i] < 16) begin
        g_port[i][g_cnt[i]] = r1[i];
        g_cyc[i][g_cnt[i]] = cyc;
      end
      g_cnt[i]++;
      $display("inst%0d cycle %0d grant port%0d", i, cyc, r1[i] ? 1 : 0);
    end
    if (rv0[i] || rv1[i]) begin
      if (r_cnt[i] < 16) begin
        r_port[i][r_cnt[i]] = rv1[i];
        r_out[i][r_cnt[i]] = rv1[i] ? ro1[i] : ro0[i];
        r_flg[i][r_cnt[i]] = rv1[i] ? rf1[i] : rf0[i];
        r_cyc[i][r_cnt[i]] = cyc;
      end
      r_cnt[i]++;
      $display("inst%0d cycle %0d rsp port%0d out %h flags %h", i, cyc, rv1[i] ? 1 : 0,
               rv1[i] ? ro1[i] : ro0[i], rv1[i] ? rf1[i] : rf0[i]);
    end
    if (i == 1 && r1[i] && qh[1][0] < qt[1][0]) fp_r1_while_p0++;
    if (i == 2 && busy[i] && alu_op[i] == 5'h1F) seen_1f = 1'b1;

    if (rst[i]) begin
      m_inf[i] = 1'b0;
      m_last[i] = 1'b1;
    end else if (m_inf[i] && cyc == m_acc[i] + lat_of(i)) begin
      m_inf[i] = 1'b0;
    end else if (!m_inf[i] && (e_r0 || e_r1)) begin
      m_inf[i] = 1'b1;
      m_acc[i] = cyc + 1;
      m_own[i] = e_r1;
      m_last[i] = e_r1;
      m_op[i].a = e_r1 ? a1[i] : a0[i];
      m_op[i].b = e_r1 ? b1[i] : b0[i];
      m_op[i].op = e_r1 ? op1[i] : op0[i];
    end
  endtask

  // The driver and the checker both run in this process: pops and input changes happen on the falling edge, sampling 1 time unit later.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[i][p]) begin
          qh[i][p]++;
          pend[i][p] = 1'b0;
        end
      end
      drive(i);
    end
    #1;
    for (int i = 0; i < N; i++) compare(i);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      g_cnt[i] = 0;
      r_cnt[i] = 0;
    end
  endtask

  task automatic wait_idle();
    bit all_idle;
    all_idle = 1'b0;
    for (int k = 0; k < 300 && !all_idle; k++) begin
      tick(1);
      all_idle = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (qh[i][0] < qt[i][0] || qh[i][1] < qt[i][1] || m_inf[i]) all_idle = 1'b0;
      end
    end
    tick(2);
    checks++;
    if (!all_idle) begin
      errors++;
      $display("FAIL drain_timeout: queues still pending, required all idle within 300 cycles");
    end
  endtask

  initial begin
    fp_r1_while_p0 = 0;
    seen_1f = 1'b0;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      m_inf[i] = 1'b0;
      m_acc[i] = 0;
      m_own[i] = 1'b0;
      m_last[i] = 1'b1;
      m_op[i] = '0;
      for (int p = 0; p < 2; p++) begin
        qh[i][p] = 0;
        qt[i][p] = 0;
        pend[i][p] = 1'b0;
      end
      drive(i);
    end
    clear_logs();
    tick(3);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;

    // Phase 1: single ADD, fixed-priority contention, and DEC at latency 4.
    push(0, 0, 8'h12, 8'h34, 5'd0);
    for (int k = 0; k < 4; k++) begin
      push(1, 0, 8'h10, 8'h01, 5'd1);
      push(1, 1, 8'hF0, 8'hFF, 5'd4);
    end
    push(2, 1, 8'h00, 8'h00, 5'd6);
    wait_idle();

    chk("add_rsp_count", 0, 8'(r_cnt[0]), 8'd1);
    chk("add_rsp_port", 0, 8'(r_port[0][0]), 8'd0);
    chk("add_rsp_out", 0, r_out[0][0], 8'h46);
    chk("add_latency", 0, 8'(r_cyc[0][0] - g_cyc[0][0]), 8'd2);
    for (int k = 0; k < 4; k++) begin
      chk("fp_grant_port0", 1, 8'(g_port[1][k]), 8'd0);
      chk("fp_rsp_out", 1, r_out[1][k], 8'h0F);
    end
    chk("fp_grant5_port1", 1, 8'(g_port[1][4]), 8'd1);
    chk("fp_ready1_while_p0", 1, 8'(fp_r1_while_p0), 8'd0);
    chk("fp_spacing", 1, 8'(g_cyc[1][1] - g_cyc[1][0]), 8'd3);
    chk("dec_rsp_port", 2, 8'(r_port[2][0]), 8'd1);
    chk("dec_rsp_out", 2, r_out[2][0], 8'hFF);
    chk("dec_rsp_flags", 2, r_flg[2][0], 8'h80);
    chk("dec_latency", 2, 8'(r_cyc[2][0] - g_cyc[2][0]), 8'd5);

    // Phase 2: round-robin contention from a fresh reset, plus an undefined opcode.
    rst[0] = 1'b1;
    tick(2);
    rst[0] = 1'b0;
    clear_logs();
    for (int k = 0; k < 2; k++) begin
      push(0, 0, 8'h10, 8'h01, 5'd1);
      push(0, 1, 8'hF0, 8'hFF, 5'd4);
    end
    push(2, 0, 8'h55, 8'hAA, 5'h1F);
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      chk("rr_grant_port", 0, 8'(g_port[0][k]), 8'(k % 2));
      chk("rr_rsp_port", 0, 8'(r_port[0][k]), 8'(k % 2));
      chk("rr_rsp_out", 0, r_out[0][k], 8'h0F);
    end
    chk("rr_spacing", 0, 8'(g_cyc[0][3] - g_cyc[0][2]), 8'd3);
    chk("undef_seen_on_alu", 2, 8'(seen_1f), 8'd1);
    chk("undef_rsp_out", 2, r_out[2][0], 8'h00);
    chk("undef_rsp_flags", 2, r_flg[2][0], 8'h01);

    // Phase 3: reset one cycle after accept aborts, then the next request completes normally.
    clear_logs();
    push(0, 0, 8'h12, 8'h34, 5'd0);
    for (int k = 0; k < 50 && g_cnt[0] == 0; k++) tick(1);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    tick(4);
    chk("abort_grants", 0, 8'(g_cnt[0]), 8'd1);
    chk("abort_no_rsp", 0, 8'(r_cnt[0]), 8'd0);
    push(0, 1, 8'h01, 8'h02, 5'd0);
    wait_idle();
    chk("after_abort_rsp_count", 0, 8'(r_cnt[0]), 8'd1);
    chk("after_abort_rsp_port", 0, 8'(r_port[0][0]), 8'd1);
    chk("after_abort_rsp_out", 0, r_out[0][0], 8'h03);
    chk("after_abort_latency", 0, 8'(r_cyc[0][0] - g_cyc[0][1]), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
